// File: rtl/vram_arbiter.sv
// Video RAM arbiter: one single-port RAM shared between the character fetch
// (one cell ahead of the beam, always first) and a CPU req/ack port.
module vram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int H_LAST = 1056,
    parameter int V_LAST = 625,
    parameter int COLS   = 100,
    parameter int CHAR_H = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       CounterX,
    input  logic [10:0]       CounterY,
    input  logic [ADDR_W-1:0] disp_base,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              disp_strobe,
    output logic [DATA_W-1:0] disp_data,
    output logic [6:0]        disp_col
);
    localparam int SUB_W = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;

    localparam logic [10:0]       X_WIDTH    = 11'(WIDTH);
    localparam logic [10:0]       X_SLOT_END = 11'(WIDTH - 1);
    localparam logic [10:0]       X_LAST     = 11'(H_LAST);
    localparam logic [10:0]       Y_LAST     = 11'(V_LAST);
    localparam logic [11:0]       Y_HEIGHT   = 12'(HEIGHT);
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(CHAR_H - 1);
    localparam logic [SUB_W-1:0]  SUB_ONE    = SUB_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              op_we_q, op_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              line_active_q, line_active_d;
    logic              slot_d_q, slot_d_d;
    logic [6:0]        col_d_q, col_d_d;
    logic              disp_strobe_q, disp_strobe_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [6:0]        disp_col_q, disp_col_d;

    logic              slot_s;
    logic [6:0]        col_s;
    logic              grant_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Display slot: column 0 at the end of the previous line, then one per cell.
    always_comb begin
        slot_s = 1'b0;
        col_s  = 7'd0;
        if (!line_active_q) begin
            slot_s = 1'b0;
        end else if (CounterX == X_LAST) begin
            slot_s = 1'b1;
            col_s  = 7'd0;
        end else if ((CounterX[2:0] == 3'b111) && (CounterX < X_SLOT_END)) begin
            slot_s = 1'b1;
            col_s  = 7'((CounterX + 11'd1) >> 3);
        end else begin
            slot_s = 1'b0;
        end
    end

    // Row bookkeeping at the end of the visible part of each line; row_base steps by COLS.
    always_comb begin
        row_base_d    = row_base_q;
        sub_d         = sub_q;
        line_active_d = line_active_q;
        if (CounterX == X_WIDTH) begin
            if (CounterY == Y_LAST) begin
                row_base_d    = disp_base;
                sub_d         = '0;
                line_active_d = 1'b1;
            end else if (({1'b0, CounterY} + 12'd1) >= Y_HEIGHT) begin
                line_active_d = 1'b0;
            end else if (sub_q == SUB_LAST) begin
                sub_d      = '0;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                sub_d = sub_q + SUB_ONE;
            end
        end else begin
            line_active_d = line_active_q;
        end
    end

    // CPU access FSM; a grant is only possible in a cycle without a display slot.
    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        grant_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !slot_s && !reset) begin
                    grant_s = 1'b1;
                    op_we_d = cpu_we;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!op_we_q) begin
                    cpu_rdata_d = mem_rdata;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
                cpu_ack_d = 1'b1;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port mux: display slot, else CPU grant, else idle.
    always_comb begin
        mem_addr_s  = '0;
        mem_we_s    = 1'b0;
        mem_wdata_s = '0;
        if (slot_s) begin
            mem_addr_s = row_base_q + {{(ADDR_W-7){1'b0}}, col_s};
        end else if (grant_s) begin
            mem_addr_s  = cpu_addr;
            mem_we_s    = cpu_we;
            mem_wdata_s = cpu_wdata;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Display pipeline: RAM data arrives the cycle after the slot, presented one cycle later.
    always_comb begin
        slot_d_d      = slot_s;
        col_d_d       = col_s;
        disp_strobe_d = slot_d_q;
        if (slot_d_q) begin
            disp_data_d = mem_rdata;
            disp_col_d  = col_d_q;
        end else begin
            disp_data_d = disp_data_q;
            disp_col_d  = disp_col_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_we_q       <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            row_base_q    <= '0;
            sub_q         <= '0;
            line_active_q <= 1'b0;
            slot_d_q      <= 1'b0;
            col_d_q       <= 7'd0;
            disp_strobe_q <= 1'b0;
            disp_data_q   <= '0;
            disp_col_q    <= 7'd0;
        end else begin
            state_q       <= state_d;
            op_we_q       <= op_we_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            row_base_q    <= row_base_d;
            sub_q         <= sub_d;
            line_active_q <= line_active_d;
            slot_d_q      <= slot_d_d;
            col_d_q       <= col_d_d;
            disp_strobe_q <= disp_strobe_d;
            disp_data_q   <= disp_data_d;
            disp_col_q    <= disp_col_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign mem_addr    = mem_addr_s;
    assign mem_we      = mem_we_s;
    assign mem_wdata   = mem_wdata_s;
    assign disp_strobe = disp_strobe_q;
    assign disp_data   = disp_data_q;
    assign disp_col    = disp_col_q;

endmodule
